// File: rtl/kbd_cmd_encoder.sv
// Player command strobes (D, E, B, F, R) to ASCII key codes.
// Rising edges become pending requests, serviced by priority into a small byte FIFO.
module kbd_cmd_encoder #(
  parameter int DEPTH     = 4,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_d,
  input  logic                     cmd_e,
  input  logic                     cmd_b,
  input  logic                     cmd_f,
  input  logic                     cmd_r,
  output logic [7:0]               kbd_out,
  output logic                     kbd_valid,
  input  logic                     kbd_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int NCMD = 5;

  // Bit index is also the priority: 0 (D) is serviced first, 4 (R) last.
  logic [NCMD-1:0] cmd_vec;
  logic [NCMD-1:0] prev_reg;
  logic [NCMD-1:0] pending_reg, pending_next;
  logic [NCMD-1:0] event_vec, merge_vec, grant_vec;
  logic [2:0]      grant_idx;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [7:0]      head_reg, head_next;
  logic            overflow_reg;

  logic            pop, push, can_accept, empty_after_pop;
  logic [7:0]      wr_data;

  assign cmd_vec = {cmd_r, cmd_f, cmd_b, cmd_e, cmd_d};

  function automatic logic [7:0] code_of(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'h44;
      3'd1:    c = 8'h45;
      3'd2:    c = 8'h42;
      3'd3:    c = 8'h46;
      default: c = 8'h52;
    endcase
    if (!UPPERCASE) c = c | 8'h20;
    return c;
  endfunction

  // An event on a bit that is still pending and not being serviced is a merge.
  genvar gi;
  generate
    for (gi = 0; gi < NCMD; gi++) begin : g_cmd
      assign event_vec[gi] = cmd_vec[gi] & ~prev_reg[gi];
      assign merge_vec[gi] = event_vec[gi] & pending_reg[gi] & ~grant_vec[gi];
    end
  endgenerate

  always_comb begin
    grant_idx = 3'd0;
    for (int i = NCMD - 1; i >= 0; i--) begin
      if (pending_reg[i]) grant_idx = 3'(i);
    end
  end

  assign kbd_valid  = (count_reg != '0);
  assign pop        = kbd_valid & kbd_ready;
  assign can_accept = (count_reg != CW'(DEPTH)) | pop;
  assign push       = (|pending_reg) & can_accept;
  assign grant_vec  = push ? (NCMD'(1) << grant_idx) : '0;
  assign wr_data    = code_of(grant_idx);

  // A new event on the bit being serviced re-arms it rather than being lost.
  assign pending_next = (pending_reg & ~grant_vec) | event_vec;

  always_comb begin
    wr_ptr_next = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    count_next  = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Registered head: bypass the write when the entry lands in an empty FIFO.
  assign empty_after_pop = (count_reg == '0) || ((count_reg == CW'(1)) && pop);

  always_comb begin
    head_next = 8'h00;
    if (count_next != '0) begin
      if (empty_after_pop && push) head_next = wr_data;
      else                         head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg     <= '0;
      pending_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= 8'h00;
      overflow_reg <= 1'b0;
    end else begin
      prev_reg     <= cmd_vec;
      pending_reg  <= pending_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      overflow_reg <= overflow_reg | (|merge_vec);
    end
  end

  assign kbd_out    = head_reg;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

endmodule
